// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: MEM/WB pipeline writer has priority, LLU results wait in a
// one-entry holding register, and a starvation FSM stalls the pipeline so held results drain.
module wb_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            llu_valid,
    output logic            llu_ready,
    input  logic [4:0]      llu_rd,
    input  logic [XLEN-1:0] llu_data,
    output logic            pipe_stall,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            llu_dropped
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] LimitVal = CntW'(STARVE_LIMIT);
    localparam logic [CntW-1:0] LimitM1  = CntW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StForce
    } state_e;

    state_e          state;
    logic [CntW-1:0] starve_cnt;

    logic            h_valid;
    logic [4:0]      h_rd;
    logic [XLEN-1:0] h_data;

    logic pipe_req;
    logic grant_h;
    logic stale;
    logic accept;
    logic h_load;
    logic h_release;
    logic denied;

    assign pipe_req  = wb_we && (wb_rd != 5'd0);
    assign grant_h   = !pipe_req && h_valid;
    // The pipeline instruction targeting the same register is younger, so the held value is dead.
    assign stale     = pipe_req && h_valid && (wb_rd == h_rd);
    assign llu_ready = !h_valid && !rst;
    assign accept    = llu_valid && llu_ready;
    assign h_load    = accept && (llu_rd != 5'd0);
    assign h_release = grant_h || stale;
    assign denied    = pipe_req && h_valid && !stale;

    // Holding register and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid     <= 1'b0;
            h_rd        <= 5'd0;
            h_data      <= '0;
            rf_we       <= 1'b0;
            rf_rd       <= 5'd0;
            rf_wdata    <= '0;
            llu_dropped <= 1'b0;
        end else begin
            llu_dropped <= stale;

            // Load and release are exclusive: a load needs H empty, a release needs H full.
            if (h_load) begin
                h_valid <= 1'b1;
                h_rd    <= llu_rd;
                h_data  <= llu_data;
            end else if (h_release) begin
                h_valid <= 1'b0;
            end

            if (pipe_req) begin
                rf_we    <= 1'b1;
                rf_rd    <= wb_rd;
                rf_wdata <= wb_data;
            end else if (h_valid) begin
                rf_we    <= 1'b1;
                rf_rd    <= h_rd;
                rf_wdata <= h_data;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    // Starvation FSM with registered stall output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            pipe_stall <= 1'b0;
            unique case (state)
                StIdle: begin
                    starve_cnt <= '0;
                    if (h_load) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (h_release) begin
                        state      <= StIdle;
                        starve_cnt <= '0;
                    end else if (denied) begin
                        if (starve_cnt != LimitVal) begin
                            starve_cnt <= starve_cnt + CntW'(1);
                        end
                        if (starve_cnt >= LimitM1) begin
                            state      <= StForce;
                            pipe_stall <= 1'b1;
                        end
                    end
                end
                StForce: begin
                    if (h_release) begin
                        state      <= StIdle;
                        starve_cnt <= '0;
                    end else begin
                        pipe_stall <= 1'b1;
                    end
                end
                default: begin
                    state      <= StIdle;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

endmodule
